// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch/execute controller for the program counter. Handshakes with
// instruction memory, then resolves one decoded instruction per EXEC cycle
// into PC load/increment strobes. Holds a small return-address stack for
// CALL/RET and halts on HLT or on a stack overflow/underflow.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   mem_ready  instruction memory has the word for the current fetch_req
//   op         decoded opcode class (NOP,JMP,JZ,SKZ,CALL,RET,HLT,reserved)
//   target     jump/call target, valid in EXEC
//   zero       ALU zero flag, valid in EXEC
//   pc_value   current PC
//   resume     leave HALT (ignored while stack_err is set)
//   fetch_req  request instruction at pc_value
//   ir_load    instruction register load strobe
//   pc_load    PC load strobe, pc_in carries the value
//   pc_inc     PC increment strobe
//   pc_in      PC load value, 0 when pc_load is low
//   halted     controller is in HALT
//   stack_err  sticky stack overflow/underflow flag
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic             zero,
  input  logic [WIDTH-1:0] pc_value,
  input  logic             resume,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_in,
  output logic             halted,
  output logic             stack_err
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_SKZ  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HLT  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             active_q;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  logic             push, pop;
  logic             outputs_en;
  logic             stack_full, stack_empty;
  logic [PTR_W-1:0] top_idx;

  // Outputs stay quiet while reset is low and for the cycle in which the
  // release has not yet been sampled, so the first fetch_req follows the
  // first edge that sees reset high.
  assign outputs_en  = reset & active_q;
  assign stack_full  = (count_q == CNT_W'(STACK_DEPTH));
  assign stack_empty = (count_q == '0);
  assign top_idx     = PTR_W'(count_q - CNT_W'(1));
  assign stack_err   = err_q & outputs_en;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_in     = '0;
    halted    = 1'b0;

    if (outputs_en) begin
      unique case (state_q)
        S_FETCH: begin
          fetch_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          state_d = S_FETCH;
          unique case (op_e'(op))
            OP_JMP: begin
              pc_load = 1'b1;
              pc_in   = target;
            end
            OP_JZ: begin
              if (zero) begin
                pc_load = 1'b1;
                pc_in   = target;
              end else begin
                pc_inc = 1'b1;
              end
            end
            OP_SKZ: begin
              if (zero) begin
                pc_load = 1'b1;
                pc_in   = pc_value + WIDTH'(2);
              end else begin
                pc_inc = 1'b1;
              end
            end
            OP_CALL: begin
              if (stack_full) begin
                err_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                push    = 1'b1;
                pc_load = 1'b1;
                pc_in   = target;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                err_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                pop     = 1'b1;
                pc_load = 1'b1;
                pc_in   = stack_q[top_idx];
              end
            end
            OP_HLT: state_d = S_HALT;
            default: pc_inc = 1'b1;  // NOP and reserved
          endcase
        end

        S_HALT: begin
          halted = 1'b1;
          if (resume && !err_q) begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push)     count_d = count_q + CNT_W'(1);
    else if (pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      count_q  <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      active_q <= 1'b1;
    end
  end

  // NOTE: the stack storage has no reset; the occupancy count alone decides
  // which entries are meaningful, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) stack_q[count_q[PTR_W-1:0]] <= pc_value + WIDTH'(1);
  end

endmodule
